// File: rtl/rca_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller:
// the state encoding and the width of the shared adder slice.
package rca_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_serial_add_ctrl_rca.sv
// 4-bit ripple-carry adder: the single arithmetic resource shared by all
// nibbles of a wide addition.
module rca_serial_add_ctrl_rca
  import rca_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/rca_serial_add_ctrl.sv
// Wide adder built from one shared 4-bit ripple-carry adder, stepping one
// nibble per cycle (LSB first) with valid/ready on both operand and result sides.
module rca_serial_add_ctrl
  import rca_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t               state;
  state_t               next_state;
  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;
  logic                 carry_reg;
  logic [IDX_W-1:0]     idx;
  logic [NIBBLE_W-1:0]  a_nib;
  logic [NIBBLE_W-1:0]  b_nib;
  logic [NIBBLE_W-1:0]  s_nib;
  logic                 c_nib;
  logic                 last;

  assign a_nib = a_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
  assign last  = (idx == LAST_IDX);
  assign busy  = (state != IDLE);

  rca_serial_add_ctrl_rca u_rca (
    .x  (a_nib),
    .y  (b_nib),
    .ci (carry_reg),
    .s  (s_nib),
    .co (c_nib)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The unused encoding falls into default and recovers to IDLE.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Unwritten sum nibbles keep their old value; idx parks on the last nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum[int'(idx)*NIBBLE_W +: NIBBLE_W] <= s_nib;
          carry_reg <= c_nib;
          if (last) begin
            cout <= c_nib;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_serial_add_ctrl.sv
// Self-checking bench for rca_serial_add_ctrl: a 4-nibble instance driven through
// a scoreboard queue, plus a 1-nibble instance for the single-slice corner.
module tb_rca_serial_add_ctrl;

  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int NT = 200;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;

  logic         v1, r1, c1, ov1, or1, co1, bz1;
  logic [3:0]   a1, b1, s1;

  logic [W:0]   expQ[$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  rca_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  rca_serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
    .a(a1), .b(b1), .cin(c1), .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1), .busy(bz1)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic popCompare(input string tag);
    logic [W:0] e;
    checkOutput({tag, "_pending"}, 64'(expQ.size()), 64'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_result"}, 64'({cout, sum}), 64'(e));
    end
  endtask

  // Offer one operand set, push its expected result, and time out_valid.
  // With hold set, in_valid stays high with different operands during RUN.
  task automatic applyStimulus(input string tag, input logic [W-1:0] xa,
                               input logic [W-1:0] xb, input logic xc, input bit hold);
    int n;
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    expQ.push_back(model(xa, xb, xc));
    tick();
    if (hold) a = ~xa;
    else in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      if (hold) checkOutput({tag, "_run_in_ready"}, 64'(in_ready), 64'd0);
      tick();
      n++;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, 64'(n), 64'(N));
  endtask

  task automatic collectResult(input string tag);
    out_ready = 1'b1;
    popCompare(tag);
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_valid_fall"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int         sent, recv, cyc, n;
    logic [W-1:0] ra, rb;
    logic       rc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    v1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_sum_cout", 64'({cout, sum}), 64'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkOutput("carry_ripple_busy", 64'(busy), 64'd1);
    collectResult("carry_ripple");

    applyStimulus("hold_valid", 16'h1234, 16'h4321, 1'b1, 1'b1);
    collectResult("hold_valid");

    applyStimulus("backpressure", 16'hA5A5, 16'h5A5A, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_result", 64'({cout, sum}), 64'h0FFFF);
      tick();
    end
    collectResult("backpressure");

    // Abort a transaction two cycles into RUN; reset must act without a clock edge.
    a = 16'h7777; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_in_ready_now", 64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_sum_cout", 64'({cout, sum}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      checkOutput("abort_no_result", 64'(out_valid), 64'd0);
    end
    applyStimulus("post_reset", 16'h0001, 16'h0001, 1'b0, 1'b0);
    collectResult("post_reset");

    // Single-nibble instance.
    a1 = 4'hF; b1 = 4'h0; c1 = 1'b1; v1 = 1'b1;
    checkOutput("n1_in_ready", 64'(r1), 64'd1);
    tick();
    v1 = 1'b0;
    n = 0;
    while (!ov1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("n1_latency", 64'(n), 64'd1);
    checkOutput("n1_result", 64'({co1, s1}), 64'h10);
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    checkOutput("n1_valid_fall", 64'(ov1), 64'd0);

    // Random traffic with gaps on both handshakes.
    sent = 0; recv = 0; cyc = 0;
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    while (recv < NT && cyc < 20000) begin
      in_valid  = (sent < NT) && ($urandom_range(0, 3) != 0);
      a = ra; b = rb; cin = rc;
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        expQ.push_back(model(ra, rb, rc));
        sent++;
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      end
      if (out_valid && out_ready) begin
        popCompare("rand");
        recv++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("rand_received", 64'(recv), 64'(NT));
    checkOutput("rand_queue_empty", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
